// File: rtl/tqvp_reg_arbiter.sv
// Two-requester arbiter onto the TinyQV peripheral register port: 3-cycle transactions (grant, access, respond), round-robin on ties.
// Optional REG_ARB_LOCK_EN: requesters can hold ownership across consecutive transactions via reqN_lock.
module tqvp_reg_arbiter #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [7:0]        req0_wdata,
`ifdef REG_ARB_LOCK_EN
    input  logic              req0_lock,
`endif
    output logic              req0_ready,
    output logic              req0_rvalid,
    output logic [7:0]        req0_rdata,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [7:0]        req1_wdata,
`ifdef REG_ARB_LOCK_EN
    input  logic              req1_lock,
`endif
    output logic              req1_ready,
    output logic              req1_rvalid,
    output logic [7:0]        req1_rdata,
    output logic [ADDR_W-1:0] address,
    output logic [7:0]        data_in,
    output logic              data_write,
    input  logic [7:0]        data_out,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t            r_state;
    logic              r_last;
    logic              r_owner;
    logic [ADDR_W-1:0] r_address;
    logic [7:0]        r_data_in;
    logic              r_data_write;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [7:0]        r_rdata0;
    logic [7:0]        r_rdata1;

    logic w_grant0;
    logic w_grant1;
    logic w_lock_hold;
    logic w_locked;
    logic w_owner_valid;

`ifdef REG_ARB_LOCK_EN
    logic r_lock;
    logic w_owner_lock;
    assign w_locked     = r_lock;
    assign w_owner_lock = r_owner ? req1_lock : req0_lock;
`else
    assign w_locked = 1'b0;
`endif

    assign w_owner_valid = r_owner ? req1_valid : req0_valid;

    // r_last names the requester granted most recently, so the other one wins a tie.
    always_comb begin
        w_grant0    = 1'b0;
        w_grant1    = 1'b0;
        w_lock_hold = 1'b0;
        if (!rst && r_state == S_IDLE) begin
            if (w_locked && w_owner_valid) begin
                w_lock_hold = 1'b1;
                w_grant0    = !r_owner;
                w_grant1    = r_owner;
            end else if (req0_valid && req1_valid) begin
                w_grant0 = r_last;
                w_grant1 = !r_last;
            end else begin
                w_grant0 = req0_valid;
                w_grant1 = req1_valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last       <= 1'b1;
            r_owner      <= 1'b0;
            r_address    <= '0;
            r_data_in    <= '0;
            r_data_write <= 1'b0;
            r_rvalid0    <= 1'b0;
            r_rvalid1    <= 1'b0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
`ifdef REG_ARB_LOCK_EN
            r_lock       <= 1'b0;
`endif
        end else begin
            r_data_write <= 1'b0;
            r_rvalid0    <= 1'b0;
            r_rvalid1    <= 1'b0;
            case (r_state)
                S_IDLE: begin
`ifdef REG_ARB_LOCK_EN
                    if (!w_lock_hold)
                        r_lock <= 1'b0;
`endif
                    if (w_grant0 || w_grant1) begin
                        r_state      <= S_ACCESS;
                        r_owner      <= w_grant1;
                        r_address    <= w_grant1 ? req1_addr  : req0_addr;
                        r_data_in    <= w_grant1 ? req1_wdata : req0_wdata;
                        r_data_write <= w_grant1 ? req1_write : req0_write;
                        if (!w_lock_hold)
                            r_last <= w_grant1;
                    end
                end
                S_ACCESS: begin
                    // Captured on writes too: the peripheral still shows the pre-write value here.
                    r_state <= S_RESP;
                    if (r_owner) begin
                        r_rdata1  <= data_out;
                        r_rvalid1 <= 1'b1;
                    end else begin
                        r_rdata0  <= data_out;
                        r_rvalid0 <= 1'b1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
`ifdef REG_ARB_LOCK_EN
                    r_lock  <= w_owner_lock;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req0_ready  = w_grant0;
    assign req1_ready  = w_grant1;
    assign req0_rvalid = r_rvalid0;
    assign req1_rvalid = r_rvalid1;
    assign req0_rdata  = r_rdata0;
    assign req1_rdata  = r_rdata1;
    assign address     = r_address;
    assign data_in     = r_data_in;
    assign data_write  = r_data_write;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_tqvp_reg_arbiter.sv
// Bench for tqvp_reg_arbiter: directed scenarios plus random traffic against a timestamp-based transaction model.
// Define REG_ARB_LOCK_EN consistently for bench and design to exercise ownership locking.
module tb_tqvp_reg_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       v[2];
    logic       w[2];
    logic [3:0] a[2];
    logic [7:0] d[2];
    logic       lk[2];
    logic       req0_ready, req0_rvalid, req1_ready, req1_rvalid;
    logic [7:0] req0_rdata, req1_rdata;
    logic [3:0] address;
    logic [7:0] data_in, data_out;
    logic       data_write, busy;

    always #5 clk = ~clk;

    tqvp_reg_arbiter #(.ADDR_W(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(v[0]), .req0_write(w[0]), .req0_addr(a[0]), .req0_wdata(d[0]),
`ifdef REG_ARB_LOCK_EN
        .req0_lock(lk[0]),
`endif
        .req0_ready(req0_ready), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
        .req1_valid(v[1]), .req1_write(w[1]), .req1_addr(a[1]), .req1_wdata(d[1]),
`ifdef REG_ARB_LOCK_EN
        .req1_lock(lk[1]),
`endif
        .req1_ready(req1_ready), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
        .address(address), .data_in(data_in), .data_write(data_write),
        .data_out(data_out), .busy(busy)
    );

    // Peripheral: register file, combinational read, write on strobe.
    logic [7:0] pmem[16];
    assign data_out = pmem[address];
    always @(posedge clk) if (data_write) pmem[address] <= data_in;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    // Reference model state.
    logic [7:0] mem[16];
    logic [7:0] m_rd[2];
    logic [3:0] m_addr;
    logic [7:0] m_din;
    int         t_g = -10;
    int         free_at = 0;
    int         last = 1;
    int         lock_own = -1;
    int         g_own = 0;
    logic       g_wr = 1'b0;
    logic [3:0] g_a;
    logic [7:0] g_d;
    int         glog[$];

    // Requester stimulus state.
    int  left[2];
    bit  need_new[2];
    bit  rnd = 0;
    bit  force_wr = 0;
    bit  lock_dir = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic newf(input int n);
        w[n] = force_wr ? 1'b1 : 1'($urandom_range(0, 1));
        a[n] = 4'($urandom_range(0, 15));
        d[n] = 8'($urandom_range(0, 255));
    endtask

    task automatic apply();
        for (int n = 0; n < 2; n++) begin
            if (rnd && left[n] == 0 && $urandom_range(0, 2) == 0) begin
                left[n] = 1;
                need_new[n] = 1;
            end
            if (need_new[n]) begin
                newf(n);
                need_new[n] = 0;
            end
            v[n] = (left[n] > 0);
            if (rnd && v[n] && $urandom_range(0, 15) == 0) begin
                v[n] = 1'b0;
                need_new[n] = 1;
            end
            lk[n] = rnd ? 1'($urandom_range(0, 1)) : (lock_dir && left[n] > 0);
        end
    endtask

    task automatic model_reset();
        t_g = -10; free_at = 0; last = 1; lock_own = -1;
        m_addr = '0; m_din = '0; m_rd[0] = '0; m_rd[1] = '0;
    endtask

    task automatic model();
        int win;
        bit busy_e;
        win = -1;
        busy_e = (cyc < free_at);
        if (rst) begin
            chk("rdy0_rst", req0_ready, 0);
            chk("rdy1_rst", req1_ready, 0);
        end else begin
            chk("busy", busy, busy_e);
            chk("addr", address, m_addr);
            chk("din", data_in, m_din);
            chk("dwr", data_write, (cyc == t_g + 1) && g_wr);
            chk("rv0", req0_rvalid, (cyc == t_g + 2) && (g_own == 0));
            chk("rv1", req1_rvalid, (cyc == t_g + 2) && (g_own == 1));
            chk("rd0", req0_rdata, m_rd[0]);
            chk("rd1", req1_rdata, m_rd[1]);
            if (!busy_e) begin
                if (lock_own >= 0) begin
                    if (v[lock_own]) win = lock_own;
                    else lock_own = -1;
                end
                if (win < 0) begin
                    if (v[0] && v[1]) win = 1 - last;
                    else if (v[0]) win = 0;
                    else if (v[1]) win = 1;
                    if (win >= 0) last = win;
                end
            end
            chk("rdy0", req0_ready, win == 0);
            chk("rdy1", req1_ready, win == 1);
        end
        if (cyc == t_g + 1) begin
            if (!rst) m_rd[g_own] = mem[g_a];
            if (g_wr) mem[g_a] = g_d;
        end
`ifdef REG_ARB_LOCK_EN
        if (!rst && cyc == t_g + 2) lock_own = lk[g_own] ? g_own : -1;
`endif
        if (win >= 0) begin
            glog.push_back(win);
            t_g = cyc; g_own = win; g_wr = w[win]; g_a = a[win]; g_d = d[win];
            m_addr = g_a; m_din = g_d; free_at = cyc + 3;
            left[win]--;
            need_new[win] = (left[win] > 0);
        end
        if (rst) model_reset();
        cyc++;
    endtask

    task automatic tick(input bit r);
        @(posedge clk);
        #1;
        rst = r;
        apply();
        @(negedge clk);
        model();
    endtask

    task automatic run_until_idle(input int max);
        int k;
        k = 0;
        do begin
            tick(0);
            k++;
        end while ((left[0] > 0 || left[1] > 0 || cyc < free_at) && k < max);
        chk("timeout", k < max, 1);
    endtask

    initial begin
        rst = 1'b1;
        for (int n = 0; n < 2; n++) begin
            left[n] = 0; need_new[n] = 0; v[n] = 0; w[n] = 0; a[n] = 0; d[n] = 0; lk[n] = 0;
        end
        for (int i = 0; i < 16; i++) begin
            mem[i]  = 8'($urandom_range(0, 255));
            pmem[i] = mem[i];
        end
        mem[3] = 8'hA5; pmem[3] = 8'hA5;
        model_reset();
        tick(1); tick(1);
        tick(0);

        // Single read of 0xA5 at address 3.
        w[0] = 0; a[0] = 4'h3; d[0] = 8'h00; left[0] = 1;
        run_until_idle(20);
        chk("rd_a5", req0_rdata, 8'hA5);

        // Single write of 0x7F to address 1 by requester 1.
        w[1] = 1; a[1] = 4'h1; d[1] = 8'h7F; left[1] = 1;
        run_until_idle(20);
        chk("pmem1", pmem[1], 8'h7F);

        // Contention straight after reset: grants alternate 0,1,0,1.
        tick(1);
        glog.delete();
        need_new[0] = 1; need_new[1] = 1; left[0] = 2; left[1] = 2;
        run_until_idle(40);
        chk("cont_n", glog.size(), 4);
        for (int i = 0; i < glog.size() && i < 4; i++) chk("cont_seq", glog[i], i % 2);

        // Back-to-back writes from requester 0.
        force_wr = 1; glog.delete();
        need_new[0] = 1; left[0] = 3;
        run_until_idle(40);
        chk("b2b_n", glog.size(), 3);
        force_wr = 0;

        // Reset during the access cycle of a read, then a tie.
        glog.delete();
        w[0] = 0; a[0] = 4'h5; left[0] = 1;
        for (int k = 0; k < 10 && glog.size() == 0; k++) tick(0);
        chk("rst_grant", glog.size(), 1);
        tick(1);
        tick(0);
        tick(0);
        glog.delete();
        need_new[0] = 1; need_new[1] = 1; left[0] = 1; left[1] = 1;
        run_until_idle(20);
        chk("rst_tie", (glog.size() > 0) ? glog[0] : -1, 0);

`ifdef REG_ARB_LOCK_EN
        // Requester 1 locks across two transactions while requester 0 waits.
        lock_dir = 1; glog.delete();
        need_new[1] = 1; left[1] = 2;
        tick(0);
        need_new[0] = 1; left[0] = 1;
        run_until_idle(40);
        chk("lock_n", glog.size(), 3);
        if (glog.size() == 3) begin
            chk("lock_g0", glog[0], 1);
            chk("lock_g1", glog[1], 1);
            chk("lock_g2", glog[2], 0);
        end
        lock_dir = 0;
`endif

        // Random traffic.
        rnd = 1;
        for (int k = 0; k < 3000; k++) tick(0);
        rnd = 0;
        left[0] = 0; left[1] = 0;
        run_until_idle(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tqvp_reg_arbiter.md
Name: tqvp_reg_arbiter

Overview:
Arbitrates two requesters onto the single byte-wide peripheral register port (address / data_in / data_write / data_out) of a TinyQV peripheral. Requester 0 is the SPI register bridge; requester 1 is an on-chip sequencer that autonomously reprograms the peripheral. The block serialises accesses, issues exactly one write strobe per accepted write, and returns captured read data to the owning requester.

Parameters:
ADDR_W, 4, width of the peripheral register address.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  synchronous, active-high reset.
req0_valid  input  1  requester 0 has a transaction pending.
req0_write  input  1  1 = write, 0 = read.
req0_addr  input  ADDR_W  target register.
req0_wdata  input  8  write data.
req0_ready  output  1  one-cycle pulse: request 0 accepted this cycle.
req0_rvalid  output  1  one-cycle pulse: response 0 available.
req0_rdata  output  8  captured peripheral data_out for request 0.
req1_*  (same seven ports as req0_*, for requester 1).
address  output  ADDR_W  to peripheral address.
data_in  output  8  to peripheral data_in.
data_write  output  1  to peripheral data_write, single-cycle strobe.
data_out  input  8  from peripheral; combinational on address.
busy  output  1  high whenever state is not IDLE.

Behaviour:
- FSM states: IDLE, ACCESS, RESP. IDLE -> ACCESS on any grant; ACCESS -> RESP unconditionally; RESP -> IDLE unconditionally. Fixed 3-cycle transaction; at most one transaction in flight.
- Arbitration happens only in IDLE. One valid: that requester wins. Both valid: round-robin; the winner is the requester not granted last. The last-grant pointer resets to 1, so requester 0 wins the first tie.
- reqN_ready is combinational: high in the IDLE cycle in which N wins; low in all other states. Requester holds valid/write/addr/wdata stable until it sees ready. Fields are sampled on the ready edge. A requester may drop valid before it is granted without side effects.
- Cycle T (IDLE, ready=1): addr and wdata are registered into address and data_in. Grant owner and write flag are stored.
- Cycle T+1 (ACCESS): address and data_in are valid. data_write=1 only if the stored write flag is set. data_out is captured into the owner's rdata register at the end of the cycle, for both reads and writes. For writes the captured value is the pre-write read-back.
- Cycle T+2 (RESP): rvalid pulses for the owner only. The other requester's rvalid stays 0.
- Cycle T+3: IDLE; a new grant is possible in this cycle. Maximum throughput is 1 transaction per 3 cycles.
- address and data_in hold their last values between transactions and do not return to 0. reqN_rdata holds until that requester's next response.
- data_write is never high outside ACCESS. It never spans two cycles.
- Reset (any state, including mid-ACCESS) forces state IDLE and last-grant=1 on the next edge. All outputs take reset values: address=0, data_in=0, data_write=0, rdata=0, ready=0, rvalid=0, busy=0. A write strobe already sampled by the peripheral before reset is not undone. No rvalid is emitted for an interrupted transaction.
- ADDR_W widths are carried through unchanged; no truncation or extension.

Optional Feature:
REG_ARB_LOCK_EN: adds inputs req0_lock and req1_lock (1 bit each).
- If the owner's lock is high in the RESP cycle, ownership is retained. In the following IDLE cycle only that owner may be granted, even if the other is valid; the pointer is not updated.
- Lock is released when the owner's lock is low in RESP, or when the owner has valid low in IDLE.
- Reset clears the lock.
Without the macro: pure round-robin as above, and the lock ports are absent.

Test Plan:
- Single read: req0 valid, read, addr=0x3; peripheral data_out=0xA5 at addr 3 -> req0_ready at T, address=3 at T+1, data_write=0 always, req0_rvalid at T+2 with req0_rdata=0xA5, busy high T+1..T+2.
- Single write: req1 write addr=0x1 wdata=0x7F -> data_write high exactly one cycle (T+1) with address=1, data_in=0x7F; req1_rvalid at T+2; req0_rvalid stays 0.
- Contention after reset: both valid continuously, distinct addresses -> grants alternate 0,1,0,1 at T, T+3, T+6, T+9; each rvalid matches its owner.
- Back-to-back same requester: req0 holds valid for 3 writes with req1 idle -> three data_write strobes 3 cycles apart; no ready while busy.
- Reset mid-ACCESS: assert rst during ACCESS of a read -> next cycle state IDLE, all outputs zero, no rvalid; a subsequent tie grants req0.
- With REG_ARB_LOCK_EN: req1 granted with lock=1 for 2 transactions while req0 is valid -> req1 gets both; req0 granted at the first IDLE after req1 drops lock.
